scpu_prog_loader: RTL and testbench

Parametrised instruction-memory loader for the serial CPU. It holds the instruction RAM, accepts a program from a host over a valid/ready word stream, and verifies a modular checksum. It then starts the CPU with a one-cycle `cpu_start` pulse and holds `cpu_enable` until the CPU reports halt. The block replaces the bench-only backdoor writes into instruction RAM and separates instruction writes from the CPU's data write enable.

---
 rtl/scpu_prog_loader_pkg.sv | 22 ++
 rtl/scpu_prog_loader_if.sv | 28 ++
 rtl/scpu_prog_loader_iram.sv | 28 ++
 rtl/scpu_prog_loader.sv | 135 +++++++++++++
 tb/tb_scpu_prog_loader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/scpu_prog_loader_pkg.sv
// Shared definitions for the serial CPU program loader: default widths and
// the loader FSM state encoding.
package scpu_prog_loader_pkg;

  localparam int INSTR_W = 16;
  localparam int IADDR_W = 8;

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_LOAD  = 3'd1,
    LDR_CHECK = 3'd2,
    LDR_START = 3'd3,
    LDR_RUN   = 3'd4,
    LDR_ERR   = 3'd5
  } ldr_state_e;

  // A new load request is only honoured while the loader is parked.
  function automatic logic ldr_can_begin(input ldr_state_e s);
    return (s == LDR_IDLE) || (s == LDR_ERR);
  endfunction

endpackage

// File: rtl/scpu_prog_loader_if.sv
// Host-side program load stream: request, valid/ready word transfer and status.
interface scpu_prog_loader_if
  import scpu_prog_loader_pkg::*;
#(
  parameter int DATA_W = INSTR_W,
  parameter int ADDR_W = IADDR_W
) ();

  logic              ld_begin;
  logic [ADDR_W:0]   ld_len;
  logic [DATA_W-1:0] ld_sum;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_err;
  logic              ld_done;

  modport master (
    output ld_begin, ld_len, ld_sum, ld_valid, ld_data,
    input  ld_ready, ld_err, ld_done
  );

  modport slave (
    input  ld_begin, ld_len, ld_sum, ld_valid, ld_data,
    output ld_ready, ld_err, ld_done
  );

endinterface

// File: rtl/scpu_prog_loader_iram.sv
// Instruction RAM: one synchronous write port for the loader, one
// combinational read port for CPU fetch. Contents are never reset.
module scpu_iram
  import scpu_prog_loader_pkg::*;
#(
  parameter int DATA_W = INSTR_W,
  parameter int ADDR_W = IADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/scpu_prog_loader.sv
// Program loader for the serial CPU: streams a program into instruction RAM,
// verifies its modular checksum, then starts the CPU and holds it enabled until halt.
module scpu_prog_loader
  import scpu_prog_loader_pkg::*;
#(
  parameter int DATA_W = INSTR_W,
  parameter int ADDR_W = IADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  scpu_prog_loader_if.slave   ld,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_datain,
  input  logic                cpu_halt,
  output logic                cpu_start,
  output logic                cpu_enable
);

  localparam logic [ADDR_W:0] DepthLen = (ADDR_W+1)'(DEPTH);

  ldr_state_e        state_q;
  logic [ADDR_W:0]   wr_ptr_q;
  logic [ADDR_W:0]   len_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] exp_sum_q;
  logic              ld_ready_q;
  logic              ld_err_q;
  logic              ld_done_q;
  logic              cpu_start_q;
  logic              cpu_enable_q;

  logic accept;
  logic lastWord;

  // ld_ready_q is only ever set while in LOAD, so it alone qualifies a write.
  assign accept   = ld.ld_valid & ld_ready_q;
  assign lastWord = accept && (wr_ptr_q == (len_q - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LDR_IDLE;
      wr_ptr_q     <= '0;
      len_q        <= '0;
      acc_q        <= '0;
      exp_sum_q    <= '0;
      ld_ready_q   <= 1'b0;
      ld_err_q     <= 1'b0;
      ld_done_q    <= 1'b0;
      cpu_start_q  <= 1'b0;
      cpu_enable_q <= 1'b0;
    end else begin
      cpu_start_q <= 1'b0;
      case (state_q)
        LDR_IDLE, LDR_ERR: begin
          if (ld.ld_begin && ldr_can_begin(state_q)) begin
            if (ld.ld_len > DepthLen) begin
              state_q  <= LDR_ERR;
              ld_err_q <= 1'b1;
            end else begin
              ld_err_q  <= 1'b0;
              len_q     <= ld.ld_len;
              exp_sum_q <= ld.ld_sum;
              wr_ptr_q  <= '0;
              acc_q     <= '0;
              if (ld.ld_len == '0) begin
                state_q <= LDR_CHECK;
              end else begin
                state_q    <= LDR_LOAD;
                ld_ready_q <= 1'b1;
              end
            end
          end
        end
        LDR_LOAD: begin
          if (accept) begin
            acc_q    <= acc_q + ld.ld_data;
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (lastWord) begin
              state_q    <= LDR_CHECK;
              ld_ready_q <= 1'b0;
            end
          end
        end
        LDR_CHECK: begin
          if (acc_q == exp_sum_q) begin
            state_q      <= LDR_START;
            cpu_start_q  <= 1'b1;
            cpu_enable_q <= 1'b1;
            ld_done_q    <= 1'b1;
          end else begin
            state_q  <= LDR_ERR;
            ld_err_q <= 1'b1;
          end
        end
        LDR_START: begin
          state_q <= LDR_RUN;
        end
        LDR_RUN: begin
          if (cpu_halt) begin
            state_q      <= LDR_IDLE;
            cpu_enable_q <= 1'b0;
            ld_done_q    <= 1'b0;
          end
        end
        default: begin
          state_q      <= LDR_IDLE;
          ld_ready_q   <= 1'b0;
          cpu_enable_q <= 1'b0;
          ld_done_q    <= 1'b0;
        end
      endcase
    end
  end

  scpu_iram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_iram (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (ld.ld_data),
    .raddr_i (i_addr),
    .rdata_o (i_datain)
  );

  assign ld.ld_ready = ld_ready_q;
  assign ld.ld_err   = ld_err_q;
  assign ld.ld_done  = ld_done_q;
  assign cpu_start   = cpu_start_q;
  assign cpu_enable  = cpu_enable_q;

endmodule

// File: tb/tb_scpu_prog_loader.sv
// Directed self-checking bench for scpu_prog_loader with hand-computed expectations.
module tb_scpu_prog_loader;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DP = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_datain;
  logic          cpu_halt = 1'b0;
  logic          cpu_start;
  logic          cpu_enable;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] prog [DP];
  logic [DW-1:0] sum;

  scpu_prog_loader_if #(.DATA_W(DW), .ADDR_W(AW)) ldIf ();

  scpu_prog_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld         (ldIf),
    .i_addr     (i_addr),
    .i_datain   (i_datain),
    .cpu_halt   (cpu_halt),
    .cpu_start  (cpu_start),
    .cpu_enable (cpu_enable)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ready"}, 32'(ldIf.ld_ready), 32'd0);
    checkOutput({tag, "_done"}, 32'(ldIf.ld_done), 32'd0);
    checkOutput({tag, "_start"}, 32'(cpu_start), 32'd0);
    checkOutput({tag, "_enable"}, 32'(cpu_enable), 32'd0);
  endtask

  task automatic applyStimulus(input logic [AW:0] len, input logic [DW-1:0] expSum);
    ldIf.ld_begin = 1'b1;
    ldIf.ld_len   = len;
    ldIf.ld_sum   = expSum;
    tick;
    ldIf.ld_begin = 1'b0;
  endtask

  task automatic sendWords(input int n, input bit stall, input bit pokeBegin);
    for (int i = 0; i < n; i++) begin
      if (stall) begin
        ldIf.ld_valid = 1'b0;
        tick;
      end
      ldIf.ld_valid = 1'b1;
      ldIf.ld_data  = prog[i];
      if (pokeBegin && i == 1) begin
        ldIf.ld_begin = 1'b1;
        ldIf.ld_len   = '0;
        ldIf.ld_sum   = '0;
      end
      tick;
      ldIf.ld_begin = 1'b0;
    end
    ldIf.ld_valid = 1'b0;
  endtask

  task automatic expectStart(input string tag);
    checkOutput({tag, "_chk_ready"}, 32'(ldIf.ld_ready), 32'd0);
    checkOutput({tag, "_chk_start"}, 32'(cpu_start), 32'd0);
    tick;
    checkOutput({tag, "_start"}, 32'(cpu_start), 32'd1);
    checkOutput({tag, "_enable"}, 32'(cpu_enable), 32'd1);
    checkOutput({tag, "_done"}, 32'(ldIf.ld_done), 32'd1);
  endtask

  task automatic haltCpu(input string tag);
    tick;
    checkOutput({tag, "_run_start"}, 32'(cpu_start), 32'd0);
    checkOutput({tag, "_run_enable"}, 32'(cpu_enable), 32'd1);
    cpu_halt = 1'b1;
    tick;
    cpu_halt = 1'b0;
    checkIdle({tag, "_halted"});
  endtask

  task automatic readMem(input string tag, input int addr, input logic [DW-1:0] expected);
    i_addr = AW'(addr);
    #1;
    checkOutput(tag, 32'(i_datain), 32'(expected));
  endtask

  initial begin
    ldIf.ld_begin = 1'b0;
    ldIf.ld_len   = '0;
    ldIf.ld_sum   = '0;
    ldIf.ld_valid = 1'b0;
    ldIf.ld_data  = '0;
    tick;
    tick;
    rst = 1'b0;
    checkIdle("reset");
    checkOutput("reset_err", 32'(ldIf.ld_err), 32'd0);

    $display("[TB] good load");
    prog[0] = 16'h0001; prog[1] = 16'h0002; prog[2] = 16'h0003;
    applyStimulus(9'd3, 16'h0006);
    checkOutput("good_ready", 32'(ldIf.ld_ready), 32'd1);
    sendWords(3, 1'b0, 1'b0);
    expectStart("good");
    readMem("good_mem1", 1, 16'h0002);
    readMem("good_mem0", 0, 16'h0001);
    readMem("good_mem2", 2, 16'h0003);
    haltCpu("good");

    $display("[TB] checksum wrap");
    prog[0] = 16'hFFFF; prog[1] = 16'h0002;
    applyStimulus(9'd2, 16'h0001);
    sendWords(2, 1'b0, 1'b0);
    expectStart("wrap_ok");
    haltCpu("wrap_ok");
    applyStimulus(9'd2, 16'h0002);
    sendWords(2, 1'b0, 1'b0);
    tick;
    checkOutput("wrap_bad_err", 32'(ldIf.ld_err), 32'd1);
    checkIdle("wrap_bad");
    tick;
    tick;
    checkOutput("wrap_bad_hold_err", 32'(ldIf.ld_err), 32'd1);
    checkOutput("wrap_bad_hold_enable", 32'(cpu_enable), 32'd0);

    $display("[TB] zero length from ERR");
    applyStimulus(9'd0, 16'h0000);
    checkOutput("zero_err_clear", 32'(ldIf.ld_err), 32'd0);
    expectStart("zero");
    haltCpu("zero");

    $display("[TB] over-length");
    applyStimulus(9'd257, 16'h0000);
    checkOutput("over_err", 32'(ldIf.ld_err), 32'd1);
    checkOutput("over_ready", 32'(ldIf.ld_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("over_ready_hold", 32'(ldIf.ld_ready), 32'd0);
    end

    $display("[TB] full depth");
    sum = '0;
    for (int i = 0; i < DP; i++) begin
      prog[i] = 16'(i * 257) ^ 16'h5A5A;
      sum = sum + prog[i];
    end
    applyStimulus(9'd256, sum);
    checkOutput("full_err_clear", 32'(ldIf.ld_err), 32'd0);
    sendWords(DP, 1'b0, 1'b0);
    expectStart("full");
    for (int i = 0; i < DP; i++) begin
      readMem("full_mem", i, prog[i]);
    end
    haltCpu("full");

    $display("[TB] stalls and ignored begin");
    prog[0] = 16'h1111; prog[1] = 16'h2222; prog[2] = 16'h3333; prog[3] = 16'h4444;
    applyStimulus(9'd4, 16'hAAAA);
    sendWords(4, 1'b1, 1'b1);
    expectStart("stall");
    readMem("stall_mem0", 0, 16'h1111);
    readMem("stall_mem1", 1, 16'h2222);
    readMem("stall_mem2", 2, 16'h3333);
    readMem("stall_mem3", 3, 16'h4444);
    readMem("stall_mem4_kept", 4, prog[4]);
    haltCpu("stall");

    $display("[TB] reset mid-load");
    prog[0] = 16'h0A0A; prog[1] = 16'h0B0B;
    applyStimulus(9'd5, 16'h1234);
    sendWords(2, 1'b0, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checkIdle("rstload");
    checkOutput("rstload_err", 32'(ldIf.ld_err), 32'd0);
    readMem("rstload_mem0", 0, 16'h0A0A);
    readMem("rstload_mem1", 1, 16'h0B0B);
    prog[0] = 16'h0100; prog[1] = 16'h0200; prog[2] = 16'h0300;
    applyStimulus(9'd3, 16'h0600);
    sendWords(3, 1'b0, 1'b0);
    expectStart("rstload_fresh");
    haltCpu("rstload_fresh");

    $display("[TB] sum-loop program to halt");
    prog[0] = 16'h1000; prog[1] = 16'h1105; prog[2] = 16'h2201;
    prog[3] = 16'h3012; prog[4] = 16'h4101; prog[5] = 16'h5002; prog[6] = 16'hF000;
    sum = '0;
    for (int i = 0; i < 7; i++) sum = sum + prog[i];
    applyStimulus(9'd7, sum);
    sendWords(7, 1'b0, 1'b0);
    expectStart("prog");
    readMem("prog_mem6", 6, 16'hF000);
    cpu_halt = 1'b1;
    tick;
    cpu_halt = 1'b0;
    checkOutput("prog_halt_in_start_ignored", 32'(cpu_enable), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick;
      checkOutput("prog_run_enable", 32'(cpu_enable), 32'd1);
    end
    cpu_halt = 1'b1;
    tick;
    cpu_halt = 1'b0;
    checkIdle("prog_halted");
    prog[0] = 16'h00FF;
    applyStimulus(9'd1, 16'h00FF);
    checkOutput("reload_ready", 32'(ldIf.ld_ready), 32'd1);
    sendWords(1, 1'b0, 1'b0);
    expectStart("reload");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
